// File: rtl/serial_sub_32.sv
// Digit-serial 32-bit subtractor: one nibble per cycle, LSB nibble first, valid/ready on both sides.
// Define SUB32_FLAGS_EN to add registered zero/ovf result flags.
module serial_sub_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        bout
`ifdef SUB32_FLAGS_EN
  ,
  output logic        zero,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] a_sh, b_sh;
  logic [27:0] res_sh;
  logic        borrow;
  logic [2:0]  cnt;
  logic        accept, last;
  logic [4:0]  sub5;
  logic [31:0] diff_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = (cnt == 3'd7);
    case (state)
      IDLE: begin
        in_ready = ~rst;
        accept   = in_valid & ~rst;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bit 4 of the 5-bit difference is the borrow into the next nibble
  always_comb begin
    sub5     = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - {4'b0000, borrow};
    diff_nxt = {sub5[3:0], res_sh};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SUB32_FLAGS_EN
      zero   <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 4;
      b_sh   <= b_sh >> 4;
      res_sh <= {sub5[3:0], res_sh[27:4]};
      borrow <= sub5[4];
      cnt    <= cnt + 3'd1;
      if (last) begin
        diff <= diff_nxt;
        bout <= sub5[4];
`ifdef SUB32_FLAGS_EN
        zero <= (diff_nxt == 32'd0);
        // signed overflow: operand signs differ and result sign differs from minuend
        ovf  <= (a_sh[3] ^ b_sh[3]) & (sub5[3] ^ a_sh[3]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_32.sv
// Directed bench for serial_sub_32: arithmetic vectors, latency, backpressure and reset abort.
module tb_serial_sub_32;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, diff;
  logic        bin, bout;
`ifdef SUB32_FLAGS_EN
  logic        zero, ovf;
`endif
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_sub_32 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef SUB32_FLAGS_EN
    , .zero(zero), .ovf(ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called just after a negedge; returns in DONE, just after a negedge
  task automatic start_op(input logic [31:0] a_v, input logic [31:0] b_v, input logic bin_v);
    int e;
    A = a_v; B = b_v; bin = bin_v; in_valid = 1'b1;
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); e = 1;
    @(negedge clk);
    in_valid = 1'b0; A = $urandom; B = $urandom; bin = ~bin_v;
    chk("run_busy", {31'b0, in_ready}, 32'd0);
    while (!out_valid && e < 30) begin
      @(posedge clk); e++;
      @(negedge clk);
    end
    chk("latency_edges", e, 32'd9);
  endtask

  task automatic chk_res(input string tag, input logic [31:0] d, input logic bo,
                         input logic z, input logic ov);
    chk({tag, "_diff"}, diff, d);
    chk({tag, "_bout"}, {31'b0, bout}, {31'b0, bo});
`ifdef SUB32_FLAGS_EN
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, z});
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, ov});
`endif
    chk({tag, "_done_ready"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_valid_low", {31'b0, out_valid}, 32'd0);
    chk("hs_idle_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic        seen_ov;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; bin = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_diff", diff, 32'd0);
    chk("rst_bout", {31'b0, bout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);

    start_op(32'd1005, 32'd69, 1'b1);
    chk_res("v1005", 32'd935, 1'b0, 1'b0, 1'b0);
    handshake();
    chk("idle_keeps_diff", diff, 32'd935);

    start_op(32'd0, 32'hFFFF_FFFF, 1'b0);
    chk_res("v0_max", 32'd1, 1'b1, 1'b0, 1'b0);
    handshake();

    start_op(32'd5, 32'd4, 1'b1);
    chk_res("v_zero", 32'd0, 1'b0, 1'b1, 1'b0);
    handshake();

    start_op(32'h8000_0000, 32'd1, 1'b0);
    chk_res("v_negovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    handshake();

    start_op(32'd0, 32'd0, 1'b1);
    chk_res("v_binonly", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    handshake();

    start_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk_res("v_posovf", 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    handshake();

    // backpressure with new operands offered the whole time
    start_op(32'd100, 32'd200, 1'b0);
    chk_res("bp", 32'hFFFF_FF9C, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; A = $urandom; B = $urandom; bin = i[0];
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_diff", diff, 32'hFFFF_FF9C);
      chk("bp_hold_bout", {31'b0, bout}, 32'd1);
      chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    end
    A = 32'h1234_5678; B = 32'h1111_1111; bin = 1'b1;
    handshake();
    start_op(32'h1234_5678, 32'h1111_1111, 1'b1);
    chk_res("bp_next", 32'h0123_4566, 1'b0, 1'b0, 1'b0);
    held = diff;
    handshake();
    chk("bp_next_kept", held, 32'h0123_4566);

    // reset abort once nibble 4 is the one in progress
    A = 32'd151242; B = 32'd53831224; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'b0, in_ready}, 32'd0);
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_diff", diff, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_rel_ready", {31'b0, in_ready}, 32'd1);
    seen_ov = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen_ov = 1'b1;
    end
    chk("abort_no_valid", {31'b0, seen_ov}, 32'd0);
    chk("abort_idle_diff", diff, 32'd0);
    chk("abort_idle_ready", {31'b0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
